// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
//   Runs one convolutional layer over a single-channel image with a single
//   line-buffered conv engine. A bank of NUM_FILTERS kernel words is loaded
//   while idle. The first pass streams the incoming frame straight through to
//   the engine and captures it in a local frame RAM. Every later pass replays
//   that frame from the RAM. The kernel for a pass is held stable for the whole
//   pass. Engine results are forwarded, tagged with the current filter index.
//
// Ports
//   clk_i, resetn_i            clock, asynchronous active-low reset
//   start_i                    begin a layer (honoured only when idle)
//   kw_we_i/kw_addr_i/kw_data_i kernel bank write port (idle only)
//   pixel_i/pixel_valid_i      input pixel stream, raster order
//   pixel_ready_o              input pixels accepted (capture pass only)
//   conv_pixel_o/conv_valid_o  pixel stream to the engine
//   conv_kernel_o              kernel word presented to the engine
//   conv_result_i/_valid_i     engine output stream
//   result_o/_valid_o          layer output stream
//   result_filter_o            filter index of result_o
//   busy_o                     layer in progress
//   done_o                     one-cycle pulse at layer end
module conv_layer_scheduler #(
  parameter int DATA_RES     = 8,
  parameter int WEIGHT_RES   = 8,
  parameter int IM_DIM       = 28,
  parameter int KERNEL_WIDTH = 3,
  parameter int KERNEL_SIZE  = 9,
  parameter int NUM_FILTERS  = 4,
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int KW = WEIGHT_RES * (KERNEL_SIZE + 1)
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                start_i,
  input  logic                kw_we_i,
  input  logic [FW-1:0]       kw_addr_i,
  input  logic [KW-1:0]       kw_data_i,
  input  logic [DATA_RES-1:0] pixel_i,
  input  logic                pixel_valid_i,
  output logic                pixel_ready_o,
  output logic [DATA_RES-1:0] conv_pixel_o,
  output logic                conv_valid_o,
  output logic [KW-1:0]       conv_kernel_o,
  input  logic [DATA_RES-1:0] conv_result_i,
  input  logic                conv_result_valid_i,
  output logic [DATA_RES-1:0] result_o,
  output logic                result_valid_o,
  output logic [FW-1:0]       result_filter_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int FRAME   = IM_DIM * IM_DIM;
  localparam int OUT_PIX = (IM_DIM - KERNEL_WIDTH + 1) * (IM_DIM - KERNEL_WIDTH + 1);
  localparam int PW      = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int CW      = $clog2(OUT_PIX + 1);
  localparam logic [PW-1:0] LAST_PIX  = PW'(FRAME - 1);
  localparam logic [CW-1:0] OUT_FULL  = CW'(OUT_PIX);
  localparam logic [FW-1:0] LAST_FILT = FW'(NUM_FILTERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_REPLAY, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       bank_q [NUM_FILTERS];
  logic [KW-1:0]       bank_d [NUM_FILTERS];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_RES-1:0] conv_pixel_q, conv_pixel_d;
  logic                conv_valid_q, conv_valid_d;
  logic [KW-1:0]       kernel_q, kernel_d;
  logic [DATA_RES-1:0] result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic [FW-1:0]       result_filter_q, result_filter_d;
  logic                cap_hs;

  logic [DATA_RES-1:0] mem [FRAME];
  logic [DATA_RES-1:0] ram_q;

  assign pixel_ready_o   = (state_q == S_CAPTURE);
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign conv_pixel_o    = conv_pixel_q;
  assign conv_valid_o    = conv_valid_q;
  assign conv_kernel_o   = kernel_q;
  assign result_o        = result_q;
  assign result_valid_o  = result_valid_q;
  assign result_filter_o = result_filter_q;

  assign cap_hs = (state_q == S_CAPTURE) && pixel_valid_i;

  always_ff @(posedge clk_i) begin
    if (cap_hs) mem[wr_ptr_q] <= pixel_i;
    ram_q <= mem[rd_ptr_q];
  end

  always_comb begin
    state_d         = state_q;
    bank_d          = bank_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    out_cnt_d       = out_cnt_q;
    filt_d          = filt_q;
    kernel_d        = kernel_q;
    rd_valid_d      = 1'b0;
    // Replay data leaves the RAM one cycle after its address; the last two
    // replayed pixels therefore still emerge after the FSM has entered DRAIN.
    conv_valid_d    = rd_valid_q;
    conv_pixel_d    = rd_valid_q ? ram_q : conv_pixel_q;
    result_d        = result_q;
    result_valid_d  = 1'b0;
    result_filter_d = result_filter_q;

    if (kw_we_i && (state_q == S_IDLE) && (int'(kw_addr_i) < NUM_FILTERS))
      bank_d[kw_addr_i] = kw_data_i;

    if (conv_result_valid_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      result_d        = conv_result_i;
      result_valid_d  = 1'b1;
      result_filter_d = filt_q;
      if (out_cnt_q != OUT_FULL) out_cnt_d = out_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CAPTURE;
          filt_d    = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          out_cnt_d = '0;
          // bank_d so a same-cycle write to slot 0 is picked up
          kernel_d  = bank_d[0];
        end
      end
      S_CAPTURE: begin
        if (cap_hs) begin
          conv_pixel_d = pixel_i;
          conv_valid_d = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_PIX) state_d = S_DRAIN;
        end
      end
      S_REPLAY: begin
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        if (rd_ptr_q == LAST_PIX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_cnt_q == OUT_FULL) begin
          out_cnt_d = '0;
          rd_ptr_d  = '0;
          if (filt_q == LAST_FILT) begin
            state_d = S_DONE;
          end else begin
            filt_d   = filt_q + 1'b1;
            kernel_d = bank_q[filt_q + 1'b1];
            state_d  = S_REPLAY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q         <= S_IDLE;
      bank_q          <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      out_cnt_q       <= '0;
      filt_q          <= '0;
      rd_valid_q      <= 1'b0;
      conv_pixel_q    <= '0;
      conv_valid_q    <= 1'b0;
      kernel_q        <= '0;
      result_q        <= '0;
      result_valid_q  <= 1'b0;
      result_filter_q <= '0;
    end else begin
      state_q         <= state_d;
      bank_q          <= bank_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      out_cnt_q       <= out_cnt_d;
      filt_q          <= filt_d;
      rd_valid_q      <= rd_valid_d;
      conv_pixel_q    <= conv_pixel_d;
      conv_valid_q    <= conv_valid_d;
      kernel_q        <= kernel_d;
      result_q        <= result_d;
      result_valid_q  <= result_valid_d;
      result_filter_q <= result_filter_d;
    end
  end

endmodule
